// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_sequencer
// Purpose  : Two-slot coin arbitration, credit tracking, dispense request and
//            coin-by-coin change payout for the beverage vending path.
// Revision : 1.0  initial release
// ============================================================================
module vend_sequencer #(
  parameter int PRICE_HALVES = 3,
  parameter int MAX_CREDIT   = 6,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int CW           = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_vld_a,
  input  logic [1:0]    coin_a,
  output logic          coin_rdy_a,
  input  logic          coin_vld_b,
  input  logic [1:0]    coin_b,
  output logic          coin_rdy_b,
  input  logic          cancel,
  output logic          disp_req,
  input  logic          disp_ack,
  output logic          chg_req,
  output logic [1:0]    chg_coin,
  input  logic          chg_ack,
  output logic          vend_done,
  output logic          coin_err,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam int            c_TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] c_PRICE     = CW'(PRICE_HALVES);
  localparam logic [CW-1:0] c_MAX       = CW'(MAX_CREDIT);
  localparam logic [CW-1:0] c_ACC_LIMIT = CW'(MAX_CREDIT - 2);
  localparam logic [CW-1:0] c_ONE       = CW'(1);
  localparam logic [CW-1:0] c_TWO       = CW'(2);
  localparam logic [c_TW-1:0] c_TLAST   = c_TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_credit, w_credit_nxt;
  logic [c_TW-1:0] r_timer, w_timer_nxt;
  logic            r_last_b;
  logic            r_chg_gap, w_chg_gap_nxt;
  logic            r_vend_done, w_vend_done_nxt;
  logic            r_coin_err;

  logic            w_open, w_grant_a, w_grant_b, w_rdy_a, w_rdy_b, w_take;
  logic [1:0]      w_code;
  logic [CW-1:0]   w_add, w_sum, w_chg_val;
  logic [CW:0]     w_sum_wide;
  logic            w_code_bad, w_chg_req;

  // Round-robin: on contention the slot that lost last time wins.
  assign w_open    = ((r_state == S_IDLE) || (r_state == S_COLLECT)) && !cancel
                     && (r_credit <= c_ACC_LIMIT);
  assign w_grant_a = coin_vld_a && (!coin_vld_b || r_last_b);
  assign w_grant_b = coin_vld_b && (!coin_vld_a || !r_last_b);
  assign w_rdy_a   = !rst && w_open && w_grant_a;
  assign w_rdy_b   = !rst && w_open && w_grant_b;
  assign w_take    = w_rdy_a || w_rdy_b;
  assign w_code    = w_rdy_a ? coin_a : coin_b;

  always_comb begin
    w_add = '0;
    case (w_code)
      2'b01:   w_add = c_ONE;
      2'b10:   w_add = c_TWO;
      default: w_add = '0;
    endcase
  end

  assign w_code_bad = w_take && ((w_code == 2'b00) || (w_code == 2'b11));
  assign w_sum_wide = {1'b0, r_credit} + {1'b0, w_add};
  assign w_sum      = (w_sum_wide > {1'b0, c_MAX}) ? c_MAX : w_sum_wide[CW-1:0];
  assign w_chg_val  = (r_credit >= c_TWO) ? c_TWO : c_ONE;
  assign w_chg_req  = (r_state == S_CHANGE) && !r_chg_gap;

  always_comb begin
    w_state_nxt     = r_state;
    w_credit_nxt    = r_credit;
    w_timer_nxt     = '0;
    w_chg_gap_nxt   = 1'b0;
    w_vend_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_credit_nxt = w_sum;
          if (w_add != '0) w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_take) w_credit_nxt = w_sum;
        if (r_credit >= c_PRICE) begin
          w_state_nxt = S_VEND;
        end else if (cancel) begin
          w_state_nxt = S_CHANGE;
        end else if (!w_take) begin
          if (r_timer == c_TLAST) w_state_nxt = S_CHANGE;
          else                    w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_VEND: begin
        if (disp_ack) begin
          w_credit_nxt    = r_credit - c_PRICE;
          w_vend_done_nxt = 1'b1;
          w_state_nxt     = (r_credit > c_PRICE) ? S_CHANGE : S_IDLE;
        end
      end
      S_CHANGE: begin
        if (r_credit == '0) begin
          w_state_nxt = S_IDLE;
        end else if (w_chg_req && chg_ack) begin
          w_credit_nxt  = r_credit - w_chg_val;
          w_chg_gap_nxt = 1'b1;
          if (r_credit == w_chg_val) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_credit    <= '0;
      r_timer     <= '0;
      r_last_b    <= 1'b1;
      r_chg_gap   <= 1'b0;
      r_vend_done <= 1'b0;
      r_coin_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_credit    <= w_credit_nxt;
      r_timer     <= w_timer_nxt;
      r_chg_gap   <= w_chg_gap_nxt;
      r_vend_done <= w_vend_done_nxt;
      r_coin_err  <= w_code_bad;
      if (w_take) r_last_b <= w_rdy_b;
    end
  end

  assign coin_rdy_a = w_rdy_a;
  assign coin_rdy_b = w_rdy_b;
  assign disp_req   = (r_state == S_VEND);
  assign chg_req    = w_chg_req;
  assign chg_coin   = w_chg_req ? ((r_credit >= c_TWO) ? 2'b10 : 2'b01) : 2'b00;
  assign vend_done  = r_vend_done;
  assign coin_err   = r_coin_err;
  assign credit     = r_credit;
  assign busy       = (r_state == S_VEND) || (r_state == S_CHANGE);

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_sequencer
// Purpose  : Directed self-checking bench for vend_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_vld_a = 1'b0, coin_vld_b = 1'b0;
  logic [1:0] coin_a = 2'b00, coin_b = 2'b00;
  logic       coin_rdy_a, coin_rdy_b;
  logic       cancel = 1'b0, disp_ack = 1'b0, chg_ack = 1'b0;
  logic       disp_req, chg_req, vend_done, coin_err, busy;
  logic [1:0] chg_coin;
  logic [3:0] credit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_sequencer dut (
    .clk(clk), .rst(rst),
    .coin_vld_a(coin_vld_a), .coin_a(coin_a), .coin_rdy_a(coin_rdy_a),
    .coin_vld_b(coin_vld_b), .coin_b(coin_b), .coin_rdy_b(coin_rdy_b),
    .cancel(cancel), .disp_req(disp_req), .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_coin(chg_coin), .chg_ack(chg_ack),
    .vend_done(vend_done), .coin_err(coin_err), .credit(credit), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (credit !== 4'd0) begin errors++; $display("FAIL rst_credit got %0d exp 0", credit); end
    checks++; if ({disp_req, chg_req, busy, vend_done, coin_err} !== 5'b0) begin
      errors++; $display("FAIL rst_outputs got %b exp 00000", {disp_req, chg_req, busy, vend_done, coin_err}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_exact_price();
    for (int k = 1; k <= 3; k++) begin
      coin_vld_a = 1'b1; coin_a = 2'b01; #1;
      checks++; if (coin_rdy_a !== 1'b1) begin errors++; $display("FAIL t1_rdy got %b exp 1", coin_rdy_a); end
      tick();
      coin_vld_a = 1'b0;
      checks++; if (credit !== 4'(k)) begin errors++; $display("FAIL t1_credit got %0d exp %0d", credit, k); end
    end
    checks++; if (disp_req !== 1'b0) begin errors++; $display("FAIL t1_disp_early got %b exp 0", disp_req); end
    tick();
    checks++; if (disp_req !== 1'b1) begin errors++; $display("FAIL t1_disp_req got %b exp 1", disp_req); end
    tick(); tick();
    checks++; if (disp_req !== 1'b1) begin errors++; $display("FAIL t1_disp_hold got %b exp 1", disp_req); end
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    checks++; if (vend_done !== 1'b1) begin errors++; $display("FAIL t1_vend_done got %b exp 1", vend_done); end
    checks++; if ({disp_req, chg_req, busy} !== 3'b000) begin errors++; $display("FAIL t1_idle got %b exp 000", {disp_req, chg_req, busy}); end
    checks++; if (credit !== 4'd0) begin errors++; $display("FAIL t1_credit_end got %0d exp 0", credit); end
    tick();
    checks++; if (vend_done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got %b exp 0", vend_done); end
  endtask

  task automatic test_change();
    for (int k = 1; k <= 2; k++) begin
      coin_vld_a = 1'b1; coin_a = 2'b10;
      tick();
      coin_vld_a = 1'b0;
      checks++; if (credit !== 4'(2 * k)) begin errors++; $display("FAIL t2_credit got %0d exp %0d", credit, 2 * k); end
    end
    for (int i = 0; i < 5 && !disp_req; i++) tick();
    checks++; if (disp_req !== 1'b1) begin errors++; $display("FAIL t2_disp_timeout got %b exp 1", disp_req); end
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    checks++; if (credit !== 4'd1) begin errors++; $display("FAIL t2_remainder got %0d exp 1", credit); end
    checks++; if (chg_req !== 1'b1 || chg_coin !== 2'b01) begin
      errors++; $display("FAIL t2_chg got req=%b coin=%b exp req=1 coin=01", chg_req, chg_coin); end
    tick();
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    checks++; if ({chg_req, busy} !== 2'b00 || credit !== 4'd0) begin
      errors++; $display("FAIL t2_idle got req/busy=%b credit=%0d exp 00 0", {chg_req, busy}, credit); end
  endtask

  task automatic test_arbitration();
    do_reset();
    coin_vld_a = 1'b1; coin_a = 2'b10; coin_vld_b = 1'b1; coin_b = 2'b10; #1;
    checks++; if ({coin_rdy_a, coin_rdy_b} !== 2'b10) begin errors++; $display("FAIL t3_first got %b exp 10", {coin_rdy_a, coin_rdy_b}); end
    tick();
    checks++; if (credit !== 4'd2) begin errors++; $display("FAIL t3_credit1 got %0d exp 2", credit); end
    checks++; if ({coin_rdy_a, coin_rdy_b} !== 2'b01) begin errors++; $display("FAIL t3_second got %b exp 01", {coin_rdy_a, coin_rdy_b}); end
    tick();
    checks++; if (credit !== 4'd4) begin errors++; $display("FAIL t3_credit2 got %0d exp 4", credit); end
    checks++; if ({coin_rdy_a, coin_rdy_b} !== 2'b10) begin errors++; $display("FAIL t3_third got %b exp 10", {coin_rdy_a, coin_rdy_b}); end
    tick();
    coin_vld_b = 1'b0; #1;
    checks++; if (credit !== 4'd6 || disp_req !== 1'b1) begin
      errors++; $display("FAIL t3_full got credit=%0d disp=%b exp 6 1", credit, disp_req); end
    checks++; if (coin_rdy_a !== 1'b0) begin errors++; $display("FAIL t3_refuse got %b exp 0", coin_rdy_a); end
    coin_vld_a = 1'b0;
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    checks++; if (credit !== 4'd3 || chg_req !== 1'b1 || chg_coin !== 2'b10) begin
      errors++; $display("FAIL t3_chg1 got credit=%0d req=%b coin=%b exp 3 1 10", credit, chg_req, chg_coin); end
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    checks++; if (credit !== 4'd1 || chg_req !== 1'b0) begin
      errors++; $display("FAIL t3_gap got credit=%0d req=%b exp 1 0", credit, chg_req); end
    tick();
    checks++; if (chg_req !== 1'b1 || chg_coin !== 2'b01) begin
      errors++; $display("FAIL t3_chg2 got req=%b coin=%b exp 1 01", chg_req, chg_coin); end
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    checks++; if (credit !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL t3_idle got credit=%0d busy=%b exp 0 0", credit, busy); end
  endtask

  task automatic test_cancel();
    coin_vld_a = 1'b1; coin_a = 2'b01; tick(); coin_vld_a = 1'b0;
    cancel = 1'b1; coin_vld_a = 1'b1; #1;
    checks++; if (coin_rdy_a !== 1'b0) begin errors++; $display("FAIL t4_rdy got %b exp 0", coin_rdy_a); end
    tick();
    cancel = 1'b0; coin_vld_a = 1'b0;
    checks++; if (chg_req !== 1'b1 || chg_coin !== 2'b01 || disp_req !== 1'b0) begin
      errors++; $display("FAIL t4_refund got req=%b coin=%b disp=%b exp 1 01 0", chg_req, chg_coin, disp_req); end
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    checks++; if (credit !== 4'd1) begin errors++; $display("FAIL t4_stray_ack got %0d exp 1", credit); end
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    checks++; if (credit !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL t4_idle got credit=%0d busy=%b exp 0 0", credit, busy); end
  endtask

  task automatic test_timeout();
    int n = 0;
    coin_vld_a = 1'b1; coin_a = 2'b10; tick(); coin_vld_a = 1'b0;
    while (!chg_req && n < 1100) begin tick(); n++; end
    checks++; if (n != 1000) begin errors++; $display("FAIL t5_timeout got %0d cycles exp 1000", n); end
    checks++; if (chg_coin !== 2'b10 || credit !== 4'd2) begin
      errors++; $display("FAIL t5_chg got coin=%b credit=%0d exp 10 2", chg_coin, credit); end
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    checks++; if (credit !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL t5_idle got credit=%0d busy=%b exp 0 0", credit, busy); end
    coin_vld_a = 1'b1; coin_a = 2'b11; tick(); coin_vld_a = 1'b0;
    checks++; if (coin_err !== 1'b1 || credit !== 4'd0) begin
      errors++; $display("FAIL t5_err got err=%b credit=%0d exp 1 0", coin_err, credit); end
    tick();
    checks++; if (coin_err !== 1'b0) begin errors++; $display("FAIL t5_err_pulse got %b exp 0", coin_err); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      coin_vld_b = 1'b1; coin_b = 2'b10; tick(); coin_vld_b = 1'b0;
    end
    for (int i = 0; i < 5 && !disp_req; i++) tick();
    checks++; if (disp_req !== 1'b1 || credit !== 4'd4) begin
      errors++; $display("FAIL t6_pre got disp=%b credit=%0d exp 1 4", disp_req, credit); end
    #2; rst = 1'b1; #1;
    checks++; if ({disp_req, busy} !== 2'b00 || credit !== 4'd0) begin
      errors++; $display("FAIL t6_async got disp/busy=%b credit=%0d exp 00 0", {disp_req, busy}, credit); end
    tick();
    rst = 1'b0;
    coin_vld_a = 1'b1; coin_a = 2'b01; coin_vld_b = 1'b1; coin_b = 2'b01; #1;
    checks++; if ({coin_rdy_a, coin_rdy_b} !== 2'b10) begin
      errors++; $display("FAIL t6_grant got %b exp 10", {coin_rdy_a, coin_rdy_b}); end
    tick();
    coin_vld_a = 1'b0; coin_vld_b = 1'b0;
    checks++; if (credit !== 4'd1) begin errors++; $display("FAIL t6_credit got %0d exp 1", credit); end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_change();
    test_arbitration();
    test_cancel();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
